// File: rtl/axil_ram_slave_if.sv
// AXI4-Lite slave bus bundle for the RAM slave.
// Master drives requests; slave drives readies and responses.
interface axil_ram_slave_if;
    logic [15:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [15:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;

    modport master (
        output s_axil_araddr, s_axil_arprot, s_axil_arvalid,
        input  s_axil_arready,
        input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output s_axil_rready,
        output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        input  s_axil_awready,
        output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_wready,
        input  s_axil_bresp, s_axil_bvalid,
        output s_axil_bready
    );

    modport slave (
        input  s_axil_araddr, s_axil_arprot, s_axil_arvalid,
        output s_axil_arready,
        output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  s_axil_rready,
        input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        output s_axil_awready,
        input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_wready,
        output s_axil_bresp, s_axil_bvalid,
        input  s_axil_bready
    );
endinterface

// File: rtl/axil_ram_slave.sv
// AXI4-Lite word RAM with a registered debug read port
// and a full-word debug write port that wins lane conflicts.
module axil_ram_slave #(
    parameter int MEM_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    axil_ram_slave_if.slave s_axil,
    input  logic [15:0] debug_addr,
    output logic [31:0] debug_data,
    input  logic [15:0] debug_wr_addr,
    input  logic [31:0] debug_wr_data,
    input  logic        debug_wr_en
);

    localparam int DEPTH = 1 << MEM_LOG2;

    typedef logic [MEM_LOG2-1:0] idx_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_t;

    logic [31:0] mem [DEPTH];

    rstate_t     rstate_q, rstate_d;
    logic [31:0] rdata_q, rdata_d;

    wstate_t     wstate_q, wstate_d;
    logic        aw_lat_q, aw_lat_d;
    idx_t        awidx_q, awidx_d;
    logic        w_lat_q, w_lat_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic [31:0] debug_q;

    idx_t        ar_idx;
    idx_t        aw_idx;
    idx_t        dbg_idx;
    idx_t        dbg_wr_idx;
    idx_t        wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        aw_hs;
    logic        w_hs;
    logic        commit;
    logic        unused_ok;

    assign ar_idx     = s_axil.s_axil_araddr[MEM_LOG2+1:2];
    assign aw_idx     = s_axil.s_axil_awaddr[MEM_LOG2+1:2];
    assign dbg_idx    = debug_addr[MEM_LOG2+1:2];
    assign dbg_wr_idx = debug_wr_addr[MEM_LOG2+1:2];

    // Aliased upper and sub-word address bits, plus prot, are don't-care.
    assign unused_ok = ^{s_axil.s_axil_araddr, s_axil.s_axil_arprot,
                         s_axil.s_axil_awaddr, s_axil.s_axil_awprot,
                         debug_addr, debug_wr_addr};

    // Channel outputs; readies and valids are forced low while in reset.
    always_comb begin
        s_axil.s_axil_arready = !rst && (rstate_q == R_IDLE);
        s_axil.s_axil_rvalid  = !rst && (rstate_q == R_DATA);
        s_axil.s_axil_rdata   = rdata_q;
        s_axil.s_axil_rresp   = 2'b00;
        s_axil.s_axil_awready = !rst && (wstate_q == W_IDLE) && !aw_lat_q;
        s_axil.s_axil_wready  = !rst && (wstate_q == W_IDLE) && !w_lat_q;
        s_axil.s_axil_bvalid  = !rst && (wstate_q == W_RESP);
        s_axil.s_axil_bresp   = 2'b00;
        debug_data            = debug_q;
    end

    // Read FSM next state; data is captured at the AR handshake.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (s_axil.s_axil_arvalid) begin
                    rstate_d = R_DATA;
                    rdata_d  = mem[ar_idx];
                end
            end
            R_DATA: begin
                if (s_axil.s_axil_rready) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            rdata_q  <= rdata_d;
        end
    end

    // Write merge: a channel is available if latched or handshaking now.
    always_comb begin
        aw_hs   = s_axil.s_axil_awvalid && s_axil.s_axil_awready;
        w_hs    = s_axil.s_axil_wvalid && s_axil.s_axil_wready;
        wr_idx  = aw_lat_q ? awidx_q : aw_idx;
        wr_data = w_lat_q ? wdata_q : s_axil.s_axil_wdata;
        wr_strb = w_lat_q ? wstrb_q : s_axil.s_axil_wstrb;
        commit  = !rst && (wstate_q == W_IDLE)
                  && (aw_lat_q || aw_hs) && (w_lat_q || w_hs);
    end

    // Write FSM next state and address/data latches.
    always_comb begin
        wstate_d = wstate_q;
        aw_lat_d = aw_lat_q;
        awidx_d  = awidx_q;
        w_lat_d  = w_lat_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (commit) begin
                    wstate_d = W_RESP;
                    aw_lat_d = 1'b0;
                    w_lat_d  = 1'b0;
                end else begin
                    if (aw_hs) begin
                        aw_lat_d = 1'b1;
                        awidx_d  = aw_idx;
                    end
                    if (w_hs) begin
                        w_lat_d = 1'b1;
                        wdata_d = s_axil.s_axil_wdata;
                        wstrb_d = s_axil.s_axil_wstrb;
                    end
                end
            end
            W_RESP: begin
                if (s_axil.s_axil_bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write FSM state register; reset drops any half-latched write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            aw_lat_q <= 1'b0;
            awidx_q  <= '0;
            w_lat_q  <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            aw_lat_q <= aw_lat_d;
            awidx_q  <= awidx_d;
            w_lat_q  <= w_lat_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    // Memory array; the debug write is last so it overrides AXI lanes.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (debug_wr_en) begin
            mem[dbg_wr_idx] <= debug_wr_data;
        end
    end

    // Registered debug read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            debug_q <= '0;
        end else begin
            debug_q <= mem[dbg_idx];
        end
    end

endmodule

// File: tb/tb_axil_ram_slave.sv
// Testbench for axil_ram_slave: vector table plus
// directed multi-cycle sequences, scoreboard on read data.
module tb_axil_ram_slave;

    logic        clk;
    logic        rst;
    logic [15:0] debug_addr;
    logic [31:0] debug_data;
    logic [15:0] debug_wr_addr;
    logic [31:0] debug_wr_data;
    logic        debug_wr_en;

    axil_ram_slave_if bus ();

    axil_ram_slave #(.MEM_LOG2(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axil       (bus.slave),
        .debug_addr   (debug_addr),
        .debug_data   (debug_data),
        .debug_wr_addr(debug_wr_addr),
        .debug_wr_data(debug_wr_data),
        .debug_wr_en  (debug_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [15:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] sb [$];
    int          checks;
    int          errors;
    logic [31:0] tmp;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dbg_write(input logic [15:0] a, input logic [31:0] d);
        debug_wr_addr = a;
        debug_wr_data = d;
        debug_wr_en   = 1'b1;
        tick();
        debug_wr_en   = 1'b0;
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        bit aw_p, w_p, aw_h, w_h, got_b;
        bus.s_axil_awaddr  = a;
        bus.s_axil_wdata   = d;
        bus.s_axil_wstrb   = s;
        bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wvalid  = 1'b1;
        aw_p = 1'b1;
        w_p  = 1'b1;
        for (int k = 0; k < 50 && (aw_p || w_p); k++) begin
            aw_h = bus.s_axil_awready;
            w_h  = bus.s_axil_wready;
            tick();
            if (aw_h) begin
                aw_p = 1'b0;
                bus.s_axil_awvalid = 1'b0;
            end
            if (w_h) begin
                w_p = 1'b0;
                bus.s_axil_wvalid = 1'b0;
            end
        end
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wvalid  = 1'b0;
        if (aw_p || w_p) check("aw_w_timeout", 32'd0, 32'd1);
        got_b = 1'b0;
        for (int k = 0; k < 50 && !got_b; k++) begin
            got_b = bus.s_axil_bvalid;
            tick();
        end
        if (!got_b) check("b_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_read(input string name, input logic [15:0] a);
        bit ok;
        logic [31:0] e;
        bus.s_axil_araddr  = a;
        bus.s_axil_arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = bus.s_axil_arready;
            tick();
        end
        bus.s_axil_arvalid = 1'b0;
        if (!ok) check({name, "_ar_timeout"}, 32'd0, 32'd1);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = bus.s_axil_rvalid;
            if (!ok) tick();
        end
        if (!ok) begin
            check({name, "_r_timeout"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check(name, bus.s_axil_rdata, e);
            check({name, "_rresp"}, {30'd0, bus.s_axil_rresp}, 32'd0);
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{16'h0030, 32'h12345678, 4'b1111, 16'h0030, 32'h12345678};
        vecs[1] = '{16'h0030, 32'hAAAAAAAA, 4'b0001, 16'h0030, 32'h123456AA};
        vecs[2] = '{16'h0030, 32'hBBBBBBBB, 4'b1000, 16'h0033, 32'hBB3456AA};
        vecs[3] = '{16'h0031, 32'hCCCCCCCC, 4'b0110, 16'h0030, 32'hBBCCCCAA};
        vecs[4] = '{16'h0430, 32'h00000000, 4'b0000, 16'h0030, 32'hBBCCCCAA};
        vecs[5] = '{16'h0034, 32'hFFFFFFFF, 4'b1111, 16'h0034, 32'hFFFFFFFF};
        vecs[6] = '{16'h0434, 32'h00000000, 4'b1100, 16'h0034, 32'h0000FFFF};
        vecs[7] = '{16'h03FC, 32'hCAFEF00D, 4'b1111, 16'hFFFC, 32'hCAFEF00D};
        vecs[8] = '{16'h0000, 32'h55555555, 4'b1111, 16'h0400, 32'h55555555};

        rst = 1'b1;
        debug_addr = '0;
        debug_wr_addr = '0;
        debug_wr_data = '0;
        debug_wr_en = 1'b0;
        bus.s_axil_araddr = '0;
        bus.s_axil_arprot = '0;
        bus.s_axil_arvalid = 1'b0;
        bus.s_axil_rready = 1'b1;
        bus.s_axil_awaddr = '0;
        bus.s_axil_awprot = '0;
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wdata = '0;
        bus.s_axil_wstrb = '0;
        bus.s_axil_wvalid = 1'b0;
        bus.s_axil_bready = 1'b1;
        tick();
        tick();
        tmp = {25'd0, bus.s_axil_arready, bus.s_axil_awready,
               bus.s_axil_wready, bus.s_axil_rvalid, bus.s_axil_bvalid,
               2'b00};
        check("rst_ctrl", tmp, 32'd0);
        check("rst_rdata", bus.s_axil_rdata, 32'd0);
        check("rst_debug", debug_data, 32'd0);
        rst = 1'b0;
        tick();
        tmp = {29'd0, bus.s_axil_arready, bus.s_axil_awready,
               bus.s_axil_wready};
        check("post_rst_ready", tmp, 32'd7);

        // Debug write then AXI read with latency 1
        dbg_write(16'h0010, 32'hDEADBEEF);
        bus.s_axil_araddr = 16'h0010;
        bus.s_axil_arvalid = 1'b1;
        check("r34_arready", {31'd0, bus.s_axil_arready}, 32'd1);
        tick();
        bus.s_axil_arvalid = 1'b0;
        check("r34_rvalid", {31'd0, bus.s_axil_rvalid}, 32'd1);
        check("r34_rdata", bus.s_axil_rdata, 32'hDEADBEEF);
        check("r34_rresp", {30'd0, bus.s_axil_rresp}, 32'd0);
        tick();

        // W two cycles ahead of AW, partial strobes
        dbg_write(16'h0020, 32'hAABBCCDD);
        bus.s_axil_wdata = 32'h11223344;
        bus.s_axil_wstrb = 4'b0101;
        bus.s_axil_wvalid = 1'b1;
        check("r35_wready", {31'd0, bus.s_axil_wready}, 32'd1);
        tick();
        bus.s_axil_wvalid = 1'b0;
        tmp = {29'd0, bus.s_axil_wready, bus.s_axil_awready,
               bus.s_axil_bvalid};
        check("r35_wlatched", tmp, 32'd2);
        tick();
        check("r35_no_b", {31'd0, bus.s_axil_bvalid}, 32'd0);
        bus.s_axil_awaddr = 16'h0020;
        bus.s_axil_awvalid = 1'b1;
        tick();
        bus.s_axil_awvalid = 1'b0;
        check("r35_bvalid", {31'd0, bus.s_axil_bvalid}, 32'd1);
        check("r35_bresp", {30'd0, bus.s_axil_bresp}, 32'd0);
        tick();
        sb.push_back(32'hAA22CC44);
        axi_read("r35_read", 16'h0020);

        // Read backpressure for 5 cycles
        sb.push_back(32'hDEADBEEF);
        bus.s_axil_rready = 1'b0;
        bus.s_axil_araddr = 16'h0010;
        bus.s_axil_arvalid = 1'b1;
        tick();
        bus.s_axil_arvalid = 1'b0;
        tmp = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            check("r36_rvalid", {31'd0, bus.s_axil_rvalid}, 32'd1);
            check("r36_rdata", bus.s_axil_rdata, tmp);
            check("r36_arready", {31'd0, bus.s_axil_arready}, 32'd0);
            tick();
        end
        bus.s_axil_rready = 1'b1;
        check("r36_final", {31'd0, bus.s_axil_rvalid}, 32'd1);
        tick();
        check("r36_done", {30'd0, bus.s_axil_rvalid,
              bus.s_axil_arready}, 32'd1);

        // AXI and debug write collide on index 4
        bus.s_axil_awaddr = 16'h0010;
        bus.s_axil_wdata = 32'h00000001;
        bus.s_axil_wstrb = 4'b1111;
        bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wvalid = 1'b1;
        debug_wr_addr = 16'h0010;
        debug_wr_data = 32'h00000002;
        debug_wr_en = 1'b1;
        tick();
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wvalid = 1'b0;
        debug_wr_en = 1'b0;
        check("r37_bvalid", {31'd0, bus.s_axil_bvalid}, 32'd1);
        tick();
        sb.push_back(32'h00000002);
        axi_read("r37_read", 16'h0010);

        // Aliasing and debug read port latency
        dbg_write(16'h0004, 32'h13579BDF);
        sb.push_back(32'h13579BDF);
        axi_read("r38_alias", 16'h0404);
        debug_addr = 16'h0404;
        tick();
        check("r38_debug", debug_data, 32'h13579BDF);

        // Read and write to the same index on one edge
        dbg_write(16'h0040, 32'h0BADF00D);
        sb.push_back(32'h0BADF00D);
        bus.s_axil_araddr = 16'h0040;
        bus.s_axil_arvalid = 1'b1;
        bus.s_axil_awaddr = 16'h0040;
        bus.s_axil_wdata = 32'h600DCAFE;
        bus.s_axil_wstrb = 4'b1111;
        bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wvalid = 1'b1;
        tick();
        bus.s_axil_arvalid = 1'b0;
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wvalid = 1'b0;
        check("r26_old", bus.s_axil_rdata, sb.pop_front());
        check("r26_bvalid", {31'd0, bus.s_axil_bvalid}, 32'd1);
        tick();
        sb.push_back(32'h600DCAFE);
        axi_read("r26_new", 16'h0040);

        // Reset while in R_DATA
        bus.s_axil_rready = 1'b0;
        bus.s_axil_araddr = 16'h0010;
        bus.s_axil_arvalid = 1'b1;
        tick();
        bus.s_axil_arvalid = 1'b0;
        check("r39_rvalid", {31'd0, bus.s_axil_rvalid}, 32'd1);
        rst = 1'b1;
        tick();
        check("r39_rst", {30'd0, bus.s_axil_rvalid,
              bus.s_axil_arready}, 32'd0);
        rst = 1'b0;
        bus.s_axil_rready = 1'b1;
        tick();
        check("r39_after", {30'd0, bus.s_axil_rvalid,
              bus.s_axil_arready}, 32'd1);

        // Half-latched write dropped by reset
        dbg_write(16'h0050, 32'h11111111);
        bus.s_axil_awaddr = 16'h0050;
        bus.s_axil_awvalid = 1'b1;
        tick();
        bus.s_axil_awvalid = 1'b0;
        check("half_awlat", {30'd0, bus.s_axil_awready,
              bus.s_axil_wready}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.s_axil_wdata = 32'h22222222;
        bus.s_axil_wstrb = 4'b1111;
        bus.s_axil_wvalid = 1'b1;
        tick();
        bus.s_axil_wvalid = 1'b0;
        check("half_no_b", {31'd0, bus.s_axil_bvalid}, 32'd0);
        debug_addr = 16'h0050;
        tick();
        check("half_mem", debug_data, 32'h11111111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Vector table: write, then read back through the scoreboard
        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
            sb.push_back(vecs[i].exp);
            axi_read($sformatf("vec%0d", i), vecs[i].raddr);
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_ram_slave.md
AXIL_RAM_SLAVE -- requirements
Module: axil_ram_slave

Interface
REQ-001 Parameter: MEM_LOG2, default 8, log2 of memory depth in 32-bit words (256 words).
REQ-002 Ports, clock and reset first: rst synchronous, active-high; clock clk.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 s_axil_araddr  in  16  read byte address.
REQ-006 s_axil_arprot  in  3  ignored.
REQ-007 s_axil_arvalid  in  1  read address valid.
REQ-008 s_axil_arready  out  1  read address accept.
REQ-009 s_axil_rdata  out  32  read data.
REQ-010 s_axil_rresp  out  2  read response, constant 2'b00.
REQ-011 s_axil_rvalid  out  1  read data valid.
REQ-012 s_axil_rready  in  1  master accepts read data.
REQ-013 s_axil_awaddr  in  16, s_axil_awprot  in  3 (ignored), s_axil_awvalid  in  1, s_axil_awready  out  1: write address channel.
REQ-014 s_axil_wdata  in  32, s_axil_wstrb  in  4, s_axil_wvalid  in  1, s_axil_wready  out  1: write data channel.
REQ-015 s_axil_bresp  out  2 (constant 2'b00), s_axil_bvalid  out  1, s_axil_bready  in  1: write response channel.
REQ-016 debug_addr  in  16, debug_data  out  32: debug read port.
REQ-017 debug_wr_addr  in  16, debug_wr_data  in  32, debug_wr_en  in  1: debug write port.

Function
REQ-018 Word index = addr[MEM_LOG2+1:2] for every address input; address bits [1:0] and bits above MEM_LOG2+1 ignored (aliasing, no error response).
REQ-019 Read FSM states R_IDLE, R_DATA; arready = 1 exactly in R_IDLE.
REQ-020 R_IDLE with arvalid=1: capture mem[index] into rdata register, go to R_DATA; rvalid=1 the cycle after the AR handshake (latency 1).
REQ-021 R_DATA: rvalid=1, rdata held stable until rready=1; on rvalid&&rready return to R_IDLE (next AR accepted one cycle later).
REQ-022 Write FSM states W_IDLE, W_RESP; awready=1 while in W_IDLE and address not yet latched; wready=1 while in W_IDLE and data not yet latched.
REQ-023 AW and W accepted in any order or same cycle; each latched independently on its handshake.
REQ-024 On the edge where both address and data are available (latched or handshaking that cycle), write memory byte lanes where wstrb[i]=1 (lane i = bits 8i+7:8i), clear latches, go to W_RESP.
REQ-025 W_RESP: bvalid=1, awready=wready=0; on bready=1 return to W_IDLE.
REQ-026 Read and AXI write to same index on same edge: read returns pre-write data.
REQ-027 debug_data registered: debug_data = mem[debug_addr index] sampled on previous edge (1-cycle latency), reflecting writes committed on earlier edges.
REQ-028 debug_wr_en=1: full-word write of debug_wr_data at debug_wr_addr index; same edge, same index as AXI write: debug write wins for all lanes; different indices: both commit.
REQ-029 Debug port never stalls or affects AXI handshakes.
REQ-030 Memory contents undefined at power-up; not cleared by rst.

Reset
REQ-031 During rst: arready=awready=wready=0, rvalid=bvalid=0, rdata=0, debug_data=0, FSMs to R_IDLE/W_IDLE, AW/W latches cleared.
REQ-032 First cycle after rst deasserts: arready=awready=wready=1.
REQ-033 rst mid-transaction (R_DATA or W_RESP or half-latched write) abandons it; no response issued; a half-latched write is not committed.

Verification
REQ-034 Debug write 0xDEADBEEF to addr 0x0010, then AR 0x0010 with rready=1 -> arready=1 at handshake, rvalid=1 next cycle, rdata=0xDEADBEEF, rresp=0.
REQ-035 W (wdata 0x11223344, wstrb 4'b0101) two cycles before AW 0x0020 on word holding 0xAABBCCDD -> bvalid one cycle after AW handshake; subsequent read 0xAA22CC44.
REQ-036 Read with rready=0 for 5 cycles -> rvalid and rdata held stable, arready=0 throughout; completes on rready=1.
REQ-037 AXI write 0x00000001 and debug write 0x00000002 to index 4 on same edge -> read of 0x0010 returns 0x00000002; bvalid still issued.
REQ-038 Address 0x0404 with MEM_LOG2=8 -> aliases to index 1 (same data as 0x0004).
REQ-039 rst asserted while in R_DATA -> rvalid=0 next cycle, arready=1 the cycle after rst deasserts, no stale rvalid.
